// File: rtl/pipe_adder_pkg.sv
// Shared defaults and index helpers for the pipelined ripple-carry adder.
// No logic, constants and a pure function only.
// Imported by pipe_adder_stage and pipe_ripple_adder.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;

    // Base bit index of segment k when every segment is seg bits wide.
    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One SEG-bit ripple segment of the pipelined adder, with its own registers.
// Latency: one cycle from vld_in/operands to vld/carry/sum_q.
// Backpressure: every register holds while adv is low; bubbles move as vld=0.
// Optional ovf register is present only with PIPE_RIPPLE_ADDER_OVF_EN defined.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_WIDTH / DEF_STAGES,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             vld_in,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    output logic             vld,
    output logic             carry,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] sum_q
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LO = seg_lo(IDX, SEG);

    logic [SEG:0]       seg_res;
    logic [WIDTH-1:0]   sum_nxt;
    logic               load;

    // Data registers only move when a real operand set advances; bubbles
    // leave them untouched so the output holds its last result.
    assign load = adv && vld_in;

    // Ripple add of this stage's segment, carry taken from the stage below.
    assign seg_res = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]}
                   + {{SEG{1'b0}}, carry_in};

    // Lower completed segments pass through; this stage fills in its own.
    always_comb begin
        sum_nxt            = sum_in;
        sum_nxt[LO +: SEG] = seg_res[SEG-1:0];
    end

`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    logic ovf_nxt;

    // Carry into the segment MSB recovered as a^b^s, then XOR with carry out.
    // Only the top stage's value is meaningful as signed overflow.
    assign ovf_nxt = a_in[LO+SEG-1] ^ b_in[LO+SEG-1] ^ seg_res[SEG-1] ^ seg_res[SEG];

    // Overflow flag travels with the sum and holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= ovf_nxt;
        end
    end
`endif

    // Valid shifts on every advance; carry and sum load with real data only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= 1'b0;
            carry <= 1'b0;
            sum_q <= '0;
        end else if (adv) begin
            vld <= vld_in;
            if (vld_in) begin
                carry <= seg_res[SEG];
                sum_q <= sum_nxt;
            end
        end
    end

    // Skew registers: operands ride along for the segments still to be added.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

endmodule

// File: rtl/pipe_ripple_adder.sv
// WIDTH-bit adder split into STAGES ripple segments with valid/ready handshakes.
// Latency: STAGES cycles (transfer at edge N is visible after edge N+STAGES-1).
// Backpressure: in_ready = !out_valid || out_ready; the whole pipe holds together.
// Optional signed overflow output ovf when PIPE_RIPPLE_ADDER_OVF_EN is defined.
module pipe_ripple_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    // Segments must tile the word exactly.
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_ripple_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Chain index k feeds stage k; index k+1 is stage k's registered output.
    logic             vld_c   [0:STAGES];
    logic             carry_c [0:STAGES];
    logic [WIDTH-1:0] a_c     [0:STAGES];
    logic [WIDTH-1:0] b_c     [0:STAGES];
    logic [WIDTH-1:0] sum_c   [0:STAGES];
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    logic             ovf_c   [1:STAGES];
`endif

    logic adv;

    // Single global advance: the last stage is the only place a result can wait.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign vld_c[0]   = in_valid;
    assign carry_c[0] = c_in;
    assign a_c[0]     = a;
    assign b_c[0]     = b;
    assign sum_c[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .vld_in   (vld_c[k]),
            .carry_in (carry_c[k]),
            .a_in     (a_c[k]),
            .b_in     (b_c[k]),
            .sum_in   (sum_c[k]),
            .vld      (vld_c[k+1]),
            .carry    (carry_c[k+1]),
            .a_q      (a_c[k+1]),
            .b_q      (b_c[k+1]),
            .sum_q    (sum_c[k+1])
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
            ,
            .ovf      (ovf_c[k+1])
`endif
        );
    end

    // The last stage's registers are the output registers.
    assign out_valid = vld_c[STAGES];
    assign sum       = sum_c[STAGES];
    assign c_out     = carry_c[STAGES];
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    assign ovf       = ovf_c[STAGES];
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed self-checking bench for pipe_ripple_adder (WIDTH=64, STAGES=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Covers PIPE_RIPPLE_ADDER_OVF_EN when the macro is defined.
module tb_pipe_ripple_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        c_out;
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    pipe_ripple_adder #(.WIDTH(64), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated add: checks bubbles before, exact latency, result, bubble after.
    task automatic single_add(input string tag, input logic [63:0] av, input logic [63:0] bv,
                              input logic cv, input logic [63:0] es, input logic ec,
                              input logic eo);
        @(negedge clk);
        a = av; b = bv; c_in = cv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_early1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early3"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, {63'd0, c_out}, {63'd0, ec});
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) chk({tag, "_eo_arg"}, {63'd0, eo}, 64'd0);
`endif
        @(negedge clk);
        chk({tag, "_after"}, {63'd0, out_valid}, 64'd0);
    endtask

    // Eight adds a=i, b=i<<32, with out_ready low in cycles stall_lo..stall_hi.
    task automatic run_stream(input string tag, input int stall_lo, input int stall_hi,
                              input int exp_first, input int exp_last);
        int tx;
        int rx;
        int first;
        int last;
        logic [63:0] exp_sum;
        tx = 0; rx = 0; first = -1; last = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= stall_lo && c <= stall_hi);
            in_valid  = (tx < 8);
            a         = 64'(tx + 1);
            b         = 64'(tx + 1) << 32;
            c_in      = 1'b0;
            #1;
            exp_sum = 64'(rx + 1) | (64'(rx + 1) << 32);
            if (c >= stall_lo && c <= stall_hi) begin
                chk({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
                chk({tag, "_stall_in_ready"}, {63'd0, in_ready}, 64'd0);
                chk({tag, "_stall_sum_held"}, sum, exp_sum);
            end else if (out_valid) begin
                if (rx >= 8) begin
                    chk({tag, "_extra_out"}, {63'd0, out_valid}, 64'd0);
                end else begin
                    chk({tag, "_sum"}, sum, exp_sum);
                    chk({tag, "_cout"}, {63'd0, c_out}, 64'd0);
                    if (first < 0) first = c;
                    last = c;
                    rx++;
                end
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 64'(rx), 64'd8);
        chk({tag, "_first"}, 64'(first), 64'(exp_first));
        chk({tag, "_last"}, 64'(last), 64'(exp_last));
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", {63'd0, c_out}, 64'd0);
`ifdef PIPE_RIPPLE_ADDER_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single adds with hand-computed results
        single_add("basic", 64'hFF, 64'h12, 1'b0, 64'h111, 1'b0, 1'b0);
        single_add("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
        single_add("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                   64'h2222_2222_2222_2212, 1'b0, 1'b0);
        single_add("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
        single_add("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                   64'h0, 1'b1, 1'b1);

        // Back-to-back stream, then the same stream with a 5-cycle stall
        run_stream("stream", 100, 99, 4, 11);
        run_stream("stall", 5, 9, 4, 16);

        // Three adds in flight, then a one-cycle reset pulse
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 64'(i + 40); b = 64'(i + 1); c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_cout", {63'd0, c_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        single_add("post_rst", 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
